// File: rtl/rv_ctrl_pkg.sv
// Shared opcodes, ALU encodings, FSM states and funct3 -> ALU mapping
// for the RV32I multi-cycle control unit.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    // ir[30] selects SUB only for register-register ops (addi uses it as an immediate bit).
    function automatic logic [3:0] aluFromFunct(input logic [2:0] funct3,
                                                input logic       bit30,
                                                input logic       isRegOp);
        logic [3:0] sel;
        case (funct3)
            3'b000:  sel = (isRegOp && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake and data-memory request signals between the
// control unit (slave) and its fetch/memory environment (master).
interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_req;
    logic        rw;
    logic        mem_ack;

    modport master (output instr, output instr_valid, input instr_ready,
                    input mem_req, input rw, output mem_ack);
    modport slave  (input instr, input instr_valid, output instr_ready,
                    output mem_req, output rw, input mem_ack);
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational classification of the latched instruction: legality,
// load/store kind, ALU operation and operand-B source.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_bit30,
    output logic [3:0] o_aluCtrl,
    output logic       o_aluSrc,
    output logic       o_legal,
    output logic       o_isLoad,
    output logic       o_isStore
);

    always_comb begin
        o_aluCtrl = ALU_ADD;
        o_aluSrc  = 1'b0;
        o_legal   = 1'b0;
        o_isLoad  = 1'b0;
        o_isStore = 1'b0;
        case (i_opcode)
            OP_IMM: begin
                o_legal   = 1'b1;
                o_aluSrc  = 1'b1;
                o_aluCtrl = aluFromFunct(i_funct3, i_bit30, 1'b0);
            end
            OP: begin
                o_legal   = 1'b1;
                o_aluCtrl = aluFromFunct(i_funct3, i_bit30, 1'b1);
            end
            LOAD: begin
                o_legal  = (i_funct3 == F3_WORD);
                o_isLoad = o_legal;
                o_aluSrc = 1'b1;
            end
            STORE: begin
                o_legal   = (i_funct3 == F3_WORD);
                o_isStore = o_legal;
                o_aluSrc  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB),
// with memory timeout, illegal-opcode trap and retired-instruction counter.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_unit_if.slave bus,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  AluSrc,
    output logic                  RegWrite,
    output logic                  MemToReg,
    output logic                  illegal,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [31:0]       r_ir;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0]  r_retired;

    logic [3:0] w_aluCtrl;
    logic       w_aluSrc;
    logic       w_legal;
    logic       w_isLoad;
    logic       w_isStore;
    logic       w_lastMemCycle;
    logic       w_retire;
    logic       w_unused;

    alu_decoder u_aluDecoder (
        .i_opcode  (r_ir[6:0]),
        .i_funct3  (r_ir[14:12]),
        .i_bit30   (r_ir[30]),
        .o_aluCtrl (w_aluCtrl),
        .o_aluSrc  (w_aluSrc),
        .o_legal   (w_legal),
        .o_isLoad  (w_isLoad),
        .o_isStore (w_isStore)
    );

    assign w_unused       = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};
    assign w_lastMemCycle = (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_retire       = (r_state == WB) || (r_state == MEM && bus.mem_ack && w_isStore);
    assign retired        = r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_waitCnt <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == IDLE && bus.instr_valid)
                r_ir <= bus.instr;
            r_waitCnt <= (r_state == MEM && w_stateNext == MEM) ? r_waitCnt + 1'b1 : '0;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        bus.instr_ready = 1'b0;
        bus.mem_req     = 1'b0;
        bus.rw          = 1'b0;
        alu_ctrl        = '0;
        AluSrc          = 1'b0;
        RegWrite        = 1'b0;
        MemToReg        = 1'b0;
        illegal         = 1'b0;
        mem_err         = 1'b0;
        case (r_state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid)
                    w_stateNext = DECODE;
            end
            DECODE: begin
                w_stateNext = w_legal ? EXEC : IDLE;
                illegal     = !w_legal;
            end
            EXEC: begin
                alu_ctrl    = ALU_CTRL_W'(w_aluCtrl);
                AluSrc      = w_aluSrc;
                w_stateNext = (w_isLoad || w_isStore) ? MEM : WB;
            end
            MEM: begin
                alu_ctrl    = ALU_CTRL_W'(w_aluCtrl);
                AluSrc      = w_aluSrc;
                bus.mem_req = 1'b1;
                bus.rw      = w_isLoad;
                // An ack in the last allowed cycle takes priority over the timeout.
                if (bus.mem_ack) begin
                    w_stateNext = w_isLoad ? WB : IDLE;
                end else if (w_lastMemCycle) begin
                    mem_err     = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            WB: begin
                RegWrite    = 1'b1;
                MemToReg    = w_isLoad;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

endmodule
